// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES chunks with valid/ready flow control.
// Define PIPELINED_ADD_SUB_SAT_EN to make the final stage saturate sum on signed overflow.

module pipelined_add_sub_chunk #(
    parameter int C = 4
) (
    input  logic [C-1:0] a_i,
    input  logic [C-1:0] b_i,
    input  logic         c_i,
    output logic [C-1:0] s_o,
    output logic         c_o
);
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{C{1'b0}}, c_i};
endmodule

module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int C = WIDTH / STAGES;

    // a/b carry the not-yet-consumed operand chunks, s the already-resolved result chunks.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
    } stage_t;

    logic [STAGES-1:0] vld_pipe_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              stall;

    assign out_valid = vld_pipe_q[STAGES-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
        end else if (!stall) begin
            vld_pipe_q[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t       in_w;
        stage_t       raw_w;
        logic [C-1:0] s_chunk;
        logic         c_chunk;

        if (k == 0) begin : g_head
            assign in_w = {a, (sub ? ~b : b), {WIDTH{1'b0}}, sub};
        end else begin : g_body
            assign in_w = g_stage[k-1].g_mid.st_q;
        end

        pipelined_add_sub_chunk #(.C(C)) u_chunk (
            .a_i (in_w.a[k*C +: C]),
            .b_i (in_w.b[k*C +: C]),
            .c_i (in_w.c),
            .s_o (s_chunk),
            .c_o (c_chunk)
        );

        always_comb begin
            raw_w               = in_w;
            raw_w.s[k*C +: C]   = s_chunk;
            raw_w.c             = c_chunk;
        end

        if (k == STAGES - 1) begin : g_tail
            logic             cmsb;
            logic             ovf_d;
            logic [WIDTH-1:0] sum_d;
            logic             unused_ops;

            // Carry into the MSB recovered from the MSB sum bit and its operand bits.
            assign cmsb       = raw_w.a[WIDTH-1] ^ raw_w.b[WIDTH-1] ^ raw_w.s[WIDTH-1];
            assign ovf_d      = cmsb ^ raw_w.c;
            assign unused_ops = ^{raw_w.a, raw_w.b};

            always_comb begin
                sum_d = raw_w.s;
`ifdef PIPELINED_ADD_SUB_SAT_EN
                if (ovf_d)
                    sum_d = raw_w.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
`endif
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (!stall) begin
                    sum_q  <= sum_d;
                    cout_q <= raw_w.c;
                    ovf_q  <= ovf_d;
                end
            end
        end else begin : g_mid
            stage_t st_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)         st_q <= '0;
                else if (!stall) st_q <= raw_w;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub: 16-bit/4-stage directed + random, 8-bit/1-stage random.
module tb_pipelined_add_sub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
    logic [15:0] a, b, sum;
    logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8, co8, ov8;
    logic [7:0]  a8, b8, sum8;

    pipelined_add_sub #(.WIDTH(16), .STAGES(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow));

    pipelined_add_sub #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .carry_out(co8), .overflow(ov8));

    int          pass_cnt = 0, total_cnt = 0, n_out16 = 0, n_out8 = 0;
    logic [17:0] q16[$];
    logic [17:0] q8[$];
    bit          done;

    typedef struct {
        logic [15:0] a, b;
        logic        sub;
        logic [15:0] sum_mod, sum_sat;
        logic        cout, ovf;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: {ovf, cout, sum} from integer arithmetic and the same-sign overflow rule.
    function automatic logic [17:0] model(input int w, input logic [15:0] ia, input logic [15:0] ib,
                                          input logic is);
        logic [15:0] msk, beff, sm;
        logic [16:0] full;
        logic        co, ov;
        msk  = (w == 16) ? 16'hFFFF : 16'h00FF;
        beff = (is ? ~ib : ib) & msk;
        full = {1'b0, ia & msk} + {1'b0, beff} + {16'h0, is};
        sm   = full[15:0] & msk;
        co   = full[w];
        ov   = (ia[w-1] == beff[w-1]) && (sm[w-1] != ia[w-1]);
`ifdef PIPELINED_ADD_SUB_SAT_EN
        if (ov) sm = ia[w-1] ? (msk ^ (msk >> 1)) : (msk >> 1);
`endif
        return {ov, co, sm};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q16.size() == 0) chk("unexpected_out16", 32'(sum), 32'hDEAD_BEEF);
            else chk("result16", 32'({overflow, carry_out, sum}), 32'(q16.pop_front()));
            n_out16++;
        end
        if (!rst && out_valid8 && out_ready8) begin
            if (q8.size() == 0) chk("unexpected_out8", 32'(sum8), 32'hDEAD_BEEF);
            else chk("result8", 32'({ov8, co8, 8'h00, sum8}), 32'(q8.pop_front()));
            n_out8++;
        end
    end

    task automatic drive16(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                           input logic [17:0] e);
        int n = 0;
        in_valid = 1'b1; a = ia; b = ib; sub = is;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q16.push_back(e);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 200) begin chk("accept_timeout16", 32'(0), 32'(1)); break; end
        end
        in_valid = 1'b0;
    endtask

    task automatic drive8(input logic [7:0] ia, input logic [7:0] ib, input logic is);
        int n = 0;
        in_valid8 = 1'b1; a8 = ia; b8 = ib; sub8 = is;
        forever begin
            @(negedge clk);
            if (in_ready8) begin
                q8.push_back(model(8, {8'h00, ia}, {8'h00, ib}, is));
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 200) begin chk("accept_timeout8", 32'(0), 32'(1)); break; end
        end
        in_valid8 = 1'b0;
    endtask

    task automatic wait_empty16(input string nm);
        int n = 0;
        while (q16.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        chk(nm, 32'(q16.size()), 32'(0));
    endtask

    task automatic check_latency(input string nm);
        int cyc = 1;
        while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk(nm, 32'(cyc), 32'(4));
    endtask

    task automatic run_rand16();
        logic [15:0] ra, rb;
        logic        rs;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    drive16(ra, rb, rs, model(16, ra, rb, rs));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        wait_empty16("drain_rand16");
    endtask

    task automatic run_rand8();
        int n = 0;
        done = 1'b0;
        fork
            begin
                drive8(8'h7F, 8'h01, 1'b0);
                drive8(8'h80, 8'h01, 1'b1);
                drive8(8'hFF, 8'h01, 1'b0);
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    drive8(8'($urandom), 8'($urandom), 1'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready8 = ($urandom_range(0, 2) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready8 = 1'b1;
        while (q8.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        chk("drain_rand8", 32'(q8.size()), 32'(0));
        chk("count_rand8", 32'(n_out8), 32'(153));
    endtask

    initial begin
        int          n0;
        logic [17:0] held;
        logic [17:0] e;

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
        tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0};
        tbl[8] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[9] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; out_ready8 = 1'b1;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_sum", 32'(sum), 32'(0));
        chk("reset_flags", 32'({carry_out, overflow}), 32'(0));
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        chk("reset_out_valid8", 32'(out_valid8), 32'(0));
        #11 rst = 1'b0;
        @(posedge clk); #1;

        // Directed add with latency measurement.
        drive16(16'h1234, 16'h0F0F, 1'b0, {1'b0, 1'b0, 16'h2143});
        check_latency("latency_add");
        wait_empty16("drain_directed");

        // Table vectors, back-to-back.
        for (int i = 0; i < 10; i++) begin
`ifdef PIPELINED_ADD_SUB_SAT_EN
            e = {tbl[i].ovf, tbl[i].cout, tbl[i].sum_sat};
`else
            e = {tbl[i].ovf, tbl[i].cout, tbl[i].sum_mod};
`endif
            drive16(tbl[i].a, tbl[i].b, tbl[i].sub, e);
        end
        wait_empty16("drain_table");

        // Backpressure: 3-cycle stall once the first result shows up.
        n0 = n_out16;
        fork
            for (int i = 0; i < 6; i++)
                drive16(16'(16'h1111 * i), 16'h0F01, 1'(i % 2),
                        model(16, 16'(16'h1111 * i), 16'h0F01, 1'(i % 2)));
            begin
                int n = 0;
                while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
                out_ready = 1'b0;
                held = {overflow, carry_out, sum};
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'(0));
                    chk("stall_out_valid", 32'(out_valid), 32'(1));
                    chk("stall_hold", 32'({overflow, carry_out, sum}), 32'(held));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_empty16("drain_backpressure");
        chk("count_backpressure", 32'(n_out16 - n0), 32'(6));

        // Asynchronous reset with three beats in flight.
        drive16(16'h0001, 16'h0001, 1'b0, model(16, 16'h0001, 16'h0001, 1'b0));
        drive16(16'h0002, 16'h0002, 1'b0, model(16, 16'h0002, 16'h0002, 1'b0));
        drive16(16'h0003, 16'h0003, 1'b0, model(16, 16'h0003, 16'h0003, 1'b0));
        #2 rst = 1'b1;
        q16.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_outputs", 32'({overflow, carry_out, sum}), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        n0 = n_out16;
        drive16(16'h1111, 16'h2222, 1'b0, {1'b0, 1'b0, 16'h3333});
        check_latency("latency_after_reset");
        repeat (10) begin @(posedge clk); #1; end
        chk("no_stale_after_reset", 32'(n_out16 - n0), 32'(1));

        run_rand16();
        run_rand8();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined successor to the team's combinational 4-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands. The carry chain is split into STAGES register-separated chunks, so WIDTH can grow without lengthening the critical path.
- Sits between a valid/ready producer and consumer in the datapath.
- Reports carry-out and signed overflow per result.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; each stage resolves a WIDTH/STAGES-bit chunk. Legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat presented.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: a+b; 1: a-b.
- out_valid  output  1  result beat presented.
- out_ready  input  1  consumer accepts a result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry_out  output  1  carry out of the MSB. For subtraction: 1 = no borrow.
- overflow  output  1  signed (two's-complement) overflow.

Behaviour:
- Reset (asynchronous, rst=1):
  - All stage valid bits, data registers, sum, carry_out, overflow and out_valid go to 0 immediately.
  - in_ready is 1 while rst=1 is deasserted and the pipe is empty.
  - A beat in flight when reset asserts is discarded; no partial result is ever emitted.
- Chunk width: C = WIDTH/STAGES.
- Operand conditioning at acceptance:
  - b_eff = sub ? ~b : b.
  - cin = sub.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff plus the carry registered by stage k-1 (cin for k=0).
  - Registers the chunk sum and the chunk carry.
- Skew alignment:
  - Operand chunks above k travel delayed through skew registers.
  - Completed lower result chunks travel delayed through deskew registers.
  - All chunks of one beat emerge together.
- Flags (registered with the final stage):
  - carry_out = carry out of the top chunk.
  - overflow = carry into MSB XOR carry out of MSB.
- Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid=1, absent stalls.
- Throughput: one beat per cycle; back-to-back beats stay in order.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - On stall, every stage register holds and no beat is accepted.
  - Without stall, all stages advance each cycle. Bubbles (in_valid=0) propagate as valid=0 slots.
- Output stability: while out_valid=1 and out_ready=0, sum, carry_out and overflow are held stable.
- Simultaneous events:
  - Output accepted and new input accepted in the same cycle is legal. The pipe shifts, and the new beat enters stage 0.
  - in_valid=0 with out_ready=1 drains one slot per cycle.
- STAGES=1: a single registered adder, latency 1.
- Wrap-around examples (WIDTH=16):
  - FFFF+0001 → sum=0000, carry_out=1, overflow=0.
  - 7FFF+0001 → sum=8000, overflow=1.

Optional Feature:
- Macro: PIPELINED_ADD_SUB_SAT_EN.
- Defined: the final stage replaces sum with a signed-saturated value when overflow=1.
  - Positive overflow → 0111..1.
  - Negative overflow → 1000..0.
  - overflow still reports 1.
  - carry_out is unchanged.
- Undefined: sum is always the modular result; no saturation logic is built.
- Latency is identical in both builds.

Test Plan:
- Directed add, WIDTH=16, STAGES=4:
  - Stimulus: a=1234, b=0F0F, sub=0, out_ready=1.
  - Required: out_valid exactly 4 cycles after acceptance with sum=2143, carry_out=0, overflow=0.
- Cross-chunk carry:
  - Stimulus: a=00FF, b=0001, then a=FFFF, b=0001, back-to-back.
  - Required: consecutive outputs 0100 (cout=0), then 0000 (cout=1). Ripple through all chunks verified.
- Subtract and overflow:
  - 0005-0007 → FFFE, carry_out=0.
  - 8000-0001 → 7FFF, overflow=1.
  - With PIPELINED_ADD_SUB_SAT_EN: 8000-0001 → 8000, overflow=1.
- Backpressure:
  - Stimulus: stream 6 beats, holding out_ready=0 for 3 cycles once out_valid=1.
  - Required: in_ready=0 during the stall; held output is stable; all 6 results arrive in order with none lost or duplicated.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously with 3 beats in flight.
  - Required: out_valid=0 and outputs 0 immediately; after deassertion a new beat yields its correct result 4 cycles later and no stale beat appears.
- Randomised add/sub with bubbles and random out_ready, WIDTH=16, STAGES=4 and WIDTH=8, STAGES=1:
  - Required: every result matches a reference model of {cout,sum} = a ± b and the overflow rule.
